// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the conv MAC array sequencer.
// Optional feature macro used by this slice: CONV_CTRL_ABORT_EN.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCUM    = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_WAIT_OUT = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam logic [3:0] SCALE_INIT = 4'd0;
    localparam logic [3:0] SCALE_A    = 4'd1;
    localparam logic [3:0] SCALE_B    = 4'd2;
    localparam logic [3:0] SCALE_C    = 4'd3;

    // Layer mode to requantisation code.
    function automatic logic [3:0] scale_code(input logic [1:0] mode);
        logic [3:0] code;
        case (mode)
            2'd0:    code = SCALE_INIT;
            2'd1:    code = SCALE_A;
            2'd2:    code = SCALE_B;
            default: code = SCALE_C;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Handshake and control bundle between the layer FSM, the sequencer and the MAC array.
// With CONV_CTRL_ABORT_EN defined the bundle carries an extra abort request.
interface conv_seq_ctrl_if #(
    parameter int unsigned CNT_WIDTH   = 10,
    parameter int unsigned SCALE_WIDTH = 4
);
    logic                   start;
    logic [1:0]             mode;
    logic [CNT_WIDTH-1:0]   cin_groups;
    logic [CNT_WIDTH-1:0]   pix_num;
    logic                   in_valid;
    logic                   in_ready;
    logic                   adder_rst;
    logic                   acc_en;
    logic [SCALE_WIDTH-1:0] scale_in;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   done;
    logic                   state_rst;

`ifdef CONV_CTRL_ABORT_EN
    logic                   abort;

    modport master (
        output start, mode, cin_groups, pix_num, in_valid, out_ready, abort,
        input  in_ready, adder_rst, acc_en, scale_in, out_valid, busy, done, state_rst
    );
    modport slave (
        input  start, mode, cin_groups, pix_num, in_valid, out_ready, abort,
        output in_ready, adder_rst, acc_en, scale_in, out_valid, busy, done, state_rst
    );
`else
    modport master (
        output start, mode, cin_groups, pix_num, in_valid, out_ready,
        input  in_ready, adder_rst, acc_en, scale_in, out_valid, busy, done, state_rst
    );
    modport slave (
        input  start, mode, cin_groups, pix_num, in_valid, out_ready,
        output in_ready, adder_rst, acc_en, scale_in, out_valid, busy, done, state_rst
    );
`endif

endinterface

// File: rtl/ctrl_delay_line.sv
// Fixed-latency shift register aligning {adder_rst, acc_en} with the multiplier pipeline.
module ctrl_delay_line #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0][W-1:0] sr;

    // Shift one stage per cycle; clr drops every in-flight entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sr[i] <= sr[i-1];
            end
            sr[0] <= din;
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/conv_seq_ctrl.sv
// Per-tile sequencer for the conv MAC array: beat accumulation, pipeline flush,
// result handshake and pixel counting. CONV_CTRL_ABORT_EN adds a mid-tile abort.
module conv_seq_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned MAC_IN_NUM          = 9,
    parameter int unsigned MAC_OUT_NUM         = 18,
    parameter int unsigned MULT_PIPELINE_STAGE = 2,
    parameter int unsigned CNT_WIDTH           = 10,
    parameter int unsigned SCALE_WIDTH         = 4
) (
    input  logic           clk,
    input  logic           rstn,
    conv_seq_ctrl_if.slave bus
);

    localparam int unsigned S       = MULT_PIPELINE_STAGE;
    localparam int unsigned FLUSH_W = (S > 1) ? $clog2(S) : 1;

    // Reject configurations the array cannot be built with.
    if (MAC_IN_NUM == 0 || MAC_OUT_NUM == 0 || MULT_PIPELINE_STAGE == 0) begin : g_param_check
        $error("conv_seq_ctrl: MAC sizes and pipeline depth must be non-zero");
    end

    state_e                 state, state_next;
    logic [CNT_WIDTH-1:0]   beat_cnt, beat_cnt_next;
    logic [CNT_WIDTH-1:0]   pix_cnt, pix_cnt_next;
    logic [CNT_WIDTH-1:0]   cg_q, cg_next;
    logic [CNT_WIDTH-1:0]   pix_num_q, pix_num_next;
    logic [FLUSH_W-1:0]     flush_cnt, flush_cnt_next;
    logic [SCALE_WIDTH-1:0] scale_q, scale_next;
    logic                   in_ready_q, in_ready_next;
    logic                   out_valid_q, out_valid_next;
    logic                   busy_q, busy_next;
    logic                   done_q, done_next;
    logic                   state_rst_q, state_rst_next;
    logic                   beat_c;
    logic                   abort_c;
    logic [1:0]             dl_in_c;
    logic [1:0]             dl_out;

`ifdef CONV_CTRL_ABORT_EN
    assign abort_c = bus.abort && (state != ST_IDLE);
`else
    assign abort_c = 1'b0;
`endif

    assign beat_c  = bus.in_valid && in_ready_q;
    assign dl_in_c = {beat_c && (beat_cnt == '0), beat_c};

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, counter updates and next values of the registered outputs.
    always_comb begin
        state_next     = state;
        beat_cnt_next  = beat_cnt;
        pix_cnt_next   = pix_cnt;
        flush_cnt_next = flush_cnt;
        cg_next        = cg_q;
        pix_num_next   = pix_num_q;
        scale_next     = scale_q;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    cg_next        = (bus.cin_groups == '0) ? CNT_WIDTH'(1) : bus.cin_groups;
                    pix_num_next   = bus.pix_num;
                    scale_next     = SCALE_WIDTH'(scale_code(bus.mode));
                    beat_cnt_next  = '0;
                    pix_cnt_next   = '0;
                    flush_cnt_next = '0;
                    state_next     = (bus.pix_num == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat_c) begin
                    if (beat_cnt == cg_q - CNT_WIDTH'(1)) begin
                        beat_cnt_next  = '0;
                        flush_cnt_next = '0;
                        state_next     = ST_FLUSH;
                    end else begin
                        beat_cnt_next = beat_cnt + CNT_WIDTH'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == FLUSH_W'(S - 1)) begin
                    flush_cnt_next = '0;
                    state_next     = ST_WAIT_OUT;
                end else begin
                    flush_cnt_next = flush_cnt + FLUSH_W'(1);
                end
            end
            ST_WAIT_OUT: begin
                if (bus.out_ready) begin
                    pix_cnt_next = pix_cnt + CNT_WIDTH'(1);
                    state_next   = (pix_cnt == pix_num_q - CNT_WIDTH'(1)) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_DONE: begin
                pix_cnt_next = '0;
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (abort_c) begin
            state_next     = ST_IDLE;
            beat_cnt_next  = '0;
            pix_cnt_next   = '0;
            flush_cnt_next = '0;
        end

        in_ready_next  = (state_next == ST_ACCUM);
        out_valid_next = (state_next == ST_WAIT_OUT);
        busy_next      = (state_next != ST_IDLE);
        done_next      = (state_next == ST_DONE);
        state_rst_next = (state_next == ST_DONE) || abort_c;
    end

    // Counters, latched tile fields and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt    <= '0;
            pix_cnt     <= '0;
            flush_cnt   <= '0;
            cg_q        <= '0;
            pix_num_q   <= '0;
            scale_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            state_rst_q <= 1'b0;
        end else begin
            beat_cnt    <= beat_cnt_next;
            pix_cnt     <= pix_cnt_next;
            flush_cnt   <= flush_cnt_next;
            cg_q        <= cg_next;
            pix_num_q   <= pix_num_next;
            scale_q     <= scale_next;
            in_ready_q  <= in_ready_next;
            out_valid_q <= out_valid_next;
            busy_q      <= busy_next;
            done_q      <= done_next;
            state_rst_q <= state_rst_next;
        end
    end

    ctrl_delay_line #(
        .DEPTH (S),
        .W     (2)
    ) u_delay (
        .clk  (clk),
        .rstn (rstn),
        .clr  (abort_c),
        .din  (dl_in_c),
        .dout (dl_out)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_rst = state_rst_q;
    assign bus.scale_in  = scale_q;
    assign bus.adder_rst = dl_out[1];
    assign bus.acc_en    = dl_out[0];

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: table of tile scenarios plus random tiles checked cycle by
// cycle against a timeline model, and hand sequences for reset and abort.
module tb_conv_seq_ctrl;

    localparam int unsigned S     = 2;
    localparam int unsigned CW    = 10;
    localparam int unsigned SW    = 4;
    localparam int          LIMIT = 20000;

    typedef struct {
        int mode;
        int cg;
        int pix;
        int vpat;     // 0: in_valid always 1, 1: toggling 1010, 2: random
        int rpat;     // 0: out_ready always 1, 1: held 0 for 5 result cycles, 2: random
        bit junk;     // wiggle start/mode/sizes while busy
        int exp_acc;
        int exp_rst;
    } tile_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   n_checks;
    int   n_errors;
    logic [3:0] prev_scale;
    bit   beat_at[int];
    bit   first_at[int];
    tile_t tbl[9];

    conv_seq_ctrl_if #(.CNT_WIDTH(CW), .SCALE_WIDTH(SW)) bus ();

    conv_seq_ctrl #(
        .MAC_IN_NUM          (9),
        .MAC_OUT_NUM         (18),
        .MULT_PIPELINE_STAGE (S),
        .CNT_WIDTH           (CW),
        .SCALE_WIDTH         (SW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.mode       = 2'd0;
        bus.cin_groups = '0;
        bus.pix_num    = '0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
`ifdef CONV_CTRL_ABORT_EN
        bus.abort      = 1'b0;
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_busy"},      32'(bus.busy),      0);
        chk({tag, "_done"},      32'(bus.done),      0);
        chk({tag, "_state_rst"}, 32'(bus.state_rst), 0);
        chk({tag, "_acc_en"},    32'(bus.acc_en),    0);
        chk({tag, "_adder_rst"}, 32'(bus.adder_rst), 0);
        chk({tag, "_scale_in"},  32'(bus.scale_in),  0);
    endtask

    // One tile from start to done; expectations come from a timeline of events:
    // beats when tb in_valid meets the expected ready window, result S+1 cycles
    // after the last beat, next pixel the cycle after a handshake.
    task automatic run_tile(input tile_t t);
        int cg_eff, beats, pix, accum_from, result_at, done_at, guard;
        int n_acc, n_rst, n_done, c0;
        logic iv, orr, e_ir, e_ov, e_done, e_acc, e_rst;
        beat_at.delete();
        first_at.delete();
        cg_eff = (t.cg == 0) ? 1 : t.cg;
        c0 = cyc;
        bus.start      = 1'b1;
        bus.mode       = 2'(t.mode);
        bus.cin_groups = CW'(t.cg);
        bus.pix_num    = CW'(t.pix);
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_in_ready", 32'(bus.in_ready), 0);
        chk("idle_scale", 32'(bus.scale_in), 32'(prev_scale));
        beats = 0; pix = 0; result_at = -1; guard = 0;
        n_acc = 0; n_rst = 0; n_done = 0;
        if (t.pix == 0) begin
            accum_from = -1; done_at = c0 + 1;
        end else begin
            accum_from = c0 + 1; done_at = -1;
        end
        tick();
        bus.start = 1'b0;
        while (1) begin
            e_ir   = (accum_from >= 0) && (cyc >= accum_from);
            e_ov   = (result_at >= 0) && (cyc >= result_at);
            e_done = (cyc == done_at);
            e_acc  = beat_at.exists(cyc - S);
            e_rst  = first_at.exists(cyc - S);
            case (t.vpat)
                0:       iv = 1'b1;
                1:       iv = ((cyc - c0) % 2) == 1;
                default: iv = 1'($urandom_range(0, 1));
            endcase
            case (t.rpat)
                0:       orr = 1'b1;
                1:       orr = e_ov && ((cyc - result_at) >= 5);
                default: orr = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid  = iv;
            bus.out_ready = orr;
            if (t.junk) begin
                bus.start      = 1'($urandom_range(0, 1));
                bus.mode       = 2'($urandom_range(0, 3));
                bus.cin_groups = CW'($urandom_range(0, 7));
                bus.pix_num    = CW'($urandom_range(0, 7));
            end
            @(negedge clk);
            chk("in_ready",  32'(bus.in_ready),  32'(e_ir));
            chk("out_valid", 32'(bus.out_valid), 32'(e_ov));
            chk("busy",      32'(bus.busy),      1);
            chk("done",      32'(bus.done),      32'(e_done));
            chk("state_rst", 32'(bus.state_rst), 32'(e_done));
            chk("acc_en",    32'(bus.acc_en),    32'(e_acc));
            chk("adder_rst", 32'(bus.adder_rst), 32'(e_rst));
            chk("scale_in",  32'(bus.scale_in),  t.mode);
            n_acc  += int'(bus.acc_en);
            n_rst  += int'(bus.adder_rst);
            n_done += int'(bus.done);
            if (e_ir && iv) begin
                beat_at[cyc] = 1'b1;
                if (beats == 0) first_at[cyc] = 1'b1;
                beats++;
                if (beats == cg_eff) begin
                    beats = 0;
                    accum_from = -1;
                    result_at = cyc + S + 1;
                end
            end
            if (e_ov && orr) begin
                pix++;
                result_at = -1;
                if (pix == t.pix) done_at = cyc + 1;
                else accum_from = cyc + 1;
            end
            if (cyc == done_at) break;
            guard++;
            if (guard > LIMIT) begin
                n_checks++;
                n_errors++;
                $display("FAIL tile_timeout: no done after %0d cycles (mode %0d cg %0d pix %0d)",
                         guard, t.mode, t.cg, t.pix);
                break;
            end
            tick();
        end
        prev_scale = 4'(t.mode);
        chk("tile_acc_count", 32'(n_acc), 32'(t.exp_acc));
        chk("tile_rst_count", 32'(n_rst), 32'(t.exp_rst));
        chk("tile_done_count", 32'(n_done), 1);
        tick();
        idle_inputs();
    endtask

    initial begin
        tile_t rt;
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        prev_scale = 4'd0;
        idle_inputs();

        //                mode cg    pix   vpat rpat junk acc   rst
        tbl[0] = '{1,    3,    2,    0,   0,   0,   6,    2};
        tbl[1] = '{0,    4,    1,    1,   0,   0,   4,    1};
        tbl[2] = '{3,    2,    2,    0,   1,   0,   4,    2};
        tbl[3] = '{2,    0,    3,    0,   0,   0,   3,    3};
        tbl[4] = '{1,    5,    0,    0,   0,   0,   0,    0};
        tbl[5] = '{2,    3,    2,    2,   2,   1,   6,    2};
        tbl[6] = '{3,    1,    4,    2,   2,   1,   4,    4};
        tbl[7] = '{0,    1023, 1,    0,   0,   0,   1023, 1};
        tbl[8] = '{1,    1,    1023, 0,   0,   0,   1023, 1023};

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;
        tick();

        foreach (tbl[i]) run_tile(tbl[i]);

        for (int k = 0; k < 10; k++) begin
            rt.mode = int'($urandom_range(0, 3));
            rt.cg   = int'($urandom_range(0, 6));
            rt.pix  = int'($urandom_range(0, 4));
            rt.vpat = 2;
            rt.rpat = 2;
            rt.junk = 1'b1;
            rt.exp_acc = ((rt.cg == 0) ? 1 : rt.cg) * rt.pix;
            rt.exp_rst = rt.pix;
            run_tile(rt);
        end

        // Asynchronous reset in the middle of accumulation.
        bus.start = 1'b1; bus.mode = 2'd2; bus.cin_groups = CW'(5); bus.pix_num = CW'(2);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_pre_acc_en", 32'(bus.acc_en), 1);
        chk("rst_pre_scale", 32'(bus.scale_in), 2);
        #1 rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rstn = 1'b1;
        prev_scale = 4'd0;
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            chk("postrst_acc_en", 32'(bus.acc_en), 0);
            chk("postrst_busy", 32'(bus.busy), 0);
            chk("postrst_in_ready", 32'(bus.in_ready), 0);
        end
        tick();
        idle_inputs();
        run_tile(tbl[0]);

`ifdef CONV_CTRL_ABORT_EN
        // Abort is ignored while idle.
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_state_rst", 32'(bus.state_rst), 0);
        chk("idle_abort_busy", 32'(bus.busy), 0);
        tick();
        // Abort during the pipeline flush.
        bus.start = 1'b1; bus.mode = 2'd3; bus.cin_groups = CW'(2); bus.pix_num = CW'(1);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_pre_busy", 32'(bus.busy), 1);
        chk("abort_pre_acc_en", 32'(bus.acc_en), 1);
        chk("abort_pre_in_ready", 32'(bus.in_ready), 0);
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_state_rst", 32'(bus.state_rst), 1);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_in_ready", 32'(bus.in_ready), 0);
        chk("abort_acc_en", 32'(bus.acc_en), 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            chk("postabort_acc_en", 32'(bus.acc_en), 0);
            chk("postabort_state_rst", 32'(bus.state_rst), 0);
            chk("postabort_out_valid", 32'(bus.out_valid), 0);
            chk("postabort_done", 32'(bus.done), 0);
        end
        prev_scale = 4'd3;
        tick();
        idle_inputs();
        run_tile(tbl[2]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
